if_id_fetch_stage: RTL and testbench
====================================

Name: if_id_fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the pipelined RV32I core. It owns the PC and issues requests to instruction memory over a valid/ready handshake. It drives the IF_ID_instr consumed by the ID stage and the hazard detection unit. It honours the load-use stall from the hazard unit and the taken-branch flush/redirect from EX.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID on flush or fetch miss.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
stall  input  1  from hazard detection unit; holds PC and IF/ID.
flush  input  1  taken branch/jump resolved in EX; squashes IF/ID and redirects.
redirect_pc  input  32  target PC, valid when flush=1.
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch address, word aligned.
imem_ready  input  1  memory accepts request and returns imem_rdata in the same cycle.
imem_rdata  input  32  instruction word, valid when imem_req&imem_ready.
IF_ID_instr  output  32  registered instruction to ID and hazard unit.
IF_ID_pc  output  32  registered PC of IF_ID_instr.
IF_ID_valid  output  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset (async, while rst=1): pc=RESET_PC, state=FETCH, buf_valid=0, IF_ID_instr=NOP_INSTR, IF_ID_pc=0, IF_ID_valid=0. imem_req forced 0 while rst=1.
- Handshake: imem_req=1 in FETCH and DRAIN, 0 in BUFFERED. imem_addr=pc in FETCH and is held stable until imem_ready. A transfer is imem_req&imem_ready.
- FSM states: FETCH, BUFFERED, DRAIN.
- FETCH:
  - flush & transfer: drop data; pc<=redirect_pc; stay in FETCH.
  - flush & !transfer: latch redirect_pc into pending_pc; go to DRAIN.
  - !flush & transfer & !stall: IF/ID<={rdata,pc,1}; pc<=pc+4.
  - !flush & transfer & stall: buf<={rdata,pc}; buf_valid=1; pc<=pc+4; go to BUFFERED. IF/ID holds.
  - !flush & !transfer & !stall: IF/ID<={NOP_INSTR,pc,0} as a bubble.
  - !flush & !transfer & stall: hold.
- BUFFERED:
  - flush: buf_valid<=0; pc<=redirect_pc; go to FETCH.
  - !flush & !stall: IF/ID<={buf,1}; buf_valid<=0; go to FETCH.
  - stall: hold.
- DRAIN: old address stays on imem_addr.
  - On transfer: discard data; pc<=pending_pc; go to FETCH.
  - A further flush while in DRAIN overwrites pending_pc.
- Flush priority: flush has priority over stall in every state. Whenever flush=1, IF/ID<={NOP_INSTR,IF_ID_pc unchanged,0} at the same edge.
- Stall: with stall=1 and flush=0, IF_ID_* are unchanged.
- Throughput and latency: zero-wait memory (imem_ready=1) gives 1 instruction/cycle. Fetch-to-IF/ID latency is 1 cycle. Branch penalty is 1 bubble from this stage.
- PC arithmetic: PC is 32-bit and wraps modulo 2^32; 0xFFFF_FFFC+4=0. redirect_pc[1:0] is ignored and forced to 0.
- Reset mid-operation: any pending transfer, buffer or drain is abandoned. The memory must tolerate an abandoned request.

Test Plan:
- Reset then imem_ready=1 with rdata=0x00500093,0x00A00113,0x00B00193 -> IF_ID_pc 0,4,8 on consecutive cycles, valid=1, instr matches; imem_addr 0,4,8,0xC.
- Stall 2 cycles when IF_ID_pc=4 with ready=1 -> IF_ID holds pc=4; instr@8 buffered and imem_req=0 while BUFFERED; after stall drops, IF_ID_pc=8 next cycle, then 0xC.
- flush=1, redirect_pc=0x100 while IF_ID_pc=8 -> next cycle IF_ID_valid=0, IF_ID_instr=0x13; imem_addr=0x100; following cycle IF_ID_pc=0x100 valid=1.
- flush while imem_ready=0 at addr 0x10; ready rises 3 cycles later -> DRAIN holds addr 0x10, data discarded, next request addr=redirect_pc; no valid IF/ID with pc=0x10.
- imem_ready low 2 cycles with stall=0 -> two bubbles (valid=0, instr=0x13), pc unchanged; with stall=1 and flush=1 together -> bubble inserted, redirect taken.
- rst asserted mid-DRAIN and mid-BUFFERED -> immediately pc=RESET_PC, IF_ID_valid=0, imem_req=0; first fetch after release at RESET_PC.

Source files
------------

// File: rtl/if_id_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_id_fetch_stage
//
// Instruction-fetch stage and IF/ID pipeline register of the pipelined RV32I
// core. Owns the PC, fetches from instruction memory over a valid/ready
// handshake and presents the fetched word to the ID stage. Honours the
// load-use stall from the hazard unit and the taken-branch flush/redirect
// resolved in EX.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   stall        hold PC and IF/ID (load-use hazard)
//   flush        squash IF/ID and redirect fetch to redirect_pc
//   redirect_pc  branch/jump target, bits [1:0] ignored
//   imem_req     fetch request valid
//   imem_addr    word-aligned fetch address, stable until imem_ready
//   imem_ready   memory accepts the request; imem_rdata valid same cycle
//   imem_rdata   instruction word returned by memory
//   IF_ID_instr  registered instruction for ID / hazard unit
//   IF_ID_pc     PC of IF_ID_instr
//   IF_ID_valid  1 = real instruction, 0 = bubble
// ----------------------------------------------------------------------------
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_pc,
    output logic        IF_ID_valid
);

    // FETCH    : request outstanding at pc_q
    // BUFFERED : a word arrived during a stall and waits in the skid buffer
    // DRAIN    : a flush hit an unaccepted request; finish it, then redirect
    localparam logic [1:0] ST_FETCH    = 2'd0;
    localparam logic [1:0] ST_BUFFERED = 2'd1;
    localparam logic [1:0] ST_DRAIN    = 2'd2;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic        transfer;
    logic        buf_valid;
    logic [31:0] redirect_aligned;
    logic        unused_redirect_lsbs;

    // The request is withdrawn while reset is held so the memory never sees a
    // half-initialised address.
    assign imem_req  = !rst && (state_q != ST_BUFFERED);
    // In DRAIN pc_q still holds the abandoned address, which must stay on the
    // bus until the memory accepts it.
    assign imem_addr = pc_q;
    assign transfer  = imem_req && imem_ready;

    // The skid buffer holds a word exactly while in BUFFERED.
    assign buf_valid = (state_q == ST_BUFFERED);

    assign redirect_aligned     = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign IF_ID_instr = if_id_instr_q;
    assign IF_ID_pc    = if_id_pc_q;
    assign IF_ID_valid = if_id_valid_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        pending_pc_d  = pending_pc_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_valid_d = if_id_valid_q;

        case (state_q)
            ST_FETCH: begin
                if (flush) begin
                    if (transfer) begin
                        // Wrong-path word is dropped; next cycle fetches the target.
                        pc_d = redirect_aligned;
                    end else begin
                        // Request already on the bus cannot be retracted.
                        pending_pc_d = redirect_aligned;
                        state_d      = ST_DRAIN;
                    end
                end else if (transfer) begin
                    if (stall) begin
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = pc_q;
                        state_d     = ST_BUFFERED;
                    end else begin
                        if_id_instr_d = imem_rdata;
                        if_id_pc_d    = pc_q;
                        if_id_valid_d = 1'b1;
                    end
                    pc_d = pc_q + 32'd4;
                end else if (!stall) begin
                    // Fetch miss: hand ID a bubble rather than a stale instruction.
                    if_id_instr_d = NOP_INSTR;
                    if_id_pc_d    = pc_q;
                    if_id_valid_d = 1'b0;
                end
            end

            ST_BUFFERED: begin
                if (flush) begin
                    pc_d    = redirect_aligned;
                    state_d = ST_FETCH;
                end else if (!stall && buf_valid) begin
                    if_id_instr_d = buf_instr_q;
                    if_id_pc_d    = buf_pc_q;
                    if_id_valid_d = 1'b1;
                    state_d       = ST_FETCH;
                end
            end

            ST_DRAIN: begin
                // IF/ID already holds the bubble inserted by the original flush.
                if (transfer) begin
                    pc_d    = flush ? redirect_aligned : pending_pc_q;
                    state_d = ST_FETCH;
                end else if (flush) begin
                    pending_pc_d = redirect_aligned;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Flush beats stall: squash IF/ID regardless of state, PC field kept.
        if (flush) begin
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC_ALIGNED;
            pending_pc_q  <= RESET_PC_ALIGNED;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc_q    <= 32'd0;
            if_id_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q       <= state_d;
            pc_q          <= pc_d;
            pending_pc_q  <= pending_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    // NOTE: the skid buffer is data only; its contents are never observed
    // unless BUFFERED marks them valid, so it carries no reset.
    always_ff @(posedge clk) begin
        buf_instr_q <= buf_instr_d;
        buf_pc_q    <= buf_pc_d;
    end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_id_fetch_stage
//
// Directed vector table, hand-written reset sequences, then randomized
// stall/flush/ready traffic checked against a transaction-level model.
// ----------------------------------------------------------------------------
module tb_if_id_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_pc;
    logic        IF_ID_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    if_id_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .IF_ID_instr (IF_ID_instr),
        .IF_ID_pc    (IF_ID_pc),
        .IF_ID_valid (IF_ID_valid)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: the three program words at 0/4/8, a
    // recognisable address-derived pattern everywhere else.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00A0_0113;
            32'h0000_0008: return 32'h00B0_0193;
            default:       return 32'hC0DE_0000 ^ a;
        endcase
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vectors
    // ------------------------------------------------------------------
    typedef struct {
        logic        stall;
        logic        flush;
        logic        ready;
        logic [31:0] redir;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[24];

    // Called at posedge+1: drive, check the request side, cross the edge,
    // check the IF/ID side.
    task automatic run_vec(input vec_t v, input string tag);
        stall       = v.stall;
        flush       = v.flush;
        imem_ready  = v.ready;
        redirect_pc = v.redir;
        #1;
        check({tag, ".req"}, 32'(imem_req), 32'(v.exp_req));
        if (v.exp_req) check({tag, ".addr"}, imem_addr, v.exp_addr);
        @(posedge clk);
        #1;
        check({tag, ".instr"}, IF_ID_instr, v.exp_instr);
        check({tag, ".pc"},    IF_ID_pc,    v.exp_pc);
        check({tag, ".valid"}, 32'(IF_ID_valid), 32'(v.exp_valid));
    endtask

    task automatic idle_inputs();
        stall       = 1'b0;
        flush       = 1'b0;
        imem_ready  = 1'b0;
        redirect_pc = 32'd0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check({tag, ".rst_req"},   32'(imem_req), 32'd0);
        check({tag, ".rst_addr"},  imem_addr, 32'd0);
        check({tag, ".rst_instr"}, IF_ID_instr, NOP);
        check({tag, ".rst_pc"},    IF_ID_pc, 32'd0);
        check({tag, ".rst_valid"}, 32'(IF_ID_valid), 32'd0);
        rst = 1'b0;
    endtask

    // Asynchronous reset asserted between edges; outputs must react at once.
    task automatic async_reset_check(input string tag);
        rst = 1'b1;
        idle_inputs();
        #1;
        check({tag, ".req"},   32'(imem_req), 32'd0);
        check({tag, ".addr"},  imem_addr, 32'd0);
        check({tag, ".instr"}, IF_ID_instr, NOP);
        check({tag, ".pc"},    IF_ID_pc, 32'd0);
        check({tag, ".valid"}, 32'(IF_ID_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_vec('{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h0, 32'h0050_0093, 32'h0, 1'b1},
                {tag, ".first"});
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference model
    // ------------------------------------------------------------------
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ifpc;
    logic        m_valid;
    logic [63:0] m_held[$];   // word fetched during a stall: {instr, pc}
    logic [31:0] m_drain[$];  // redirect waiting for an abandoned fetch to finish

    task automatic model_reset();
        m_pc    = 32'd0;
        m_instr = NOP;
        m_ifpc  = 32'd0;
        m_valid = 1'b0;
        m_held.delete();
        m_drain.delete();
    endtask

    function automatic bit model_req();
        return m_held.size() == 0;
    endfunction

    task automatic model_step(input bit s, input bit f, input bit rdy, input logic [31:0] redir);
        logic [31:0] tgt;
        bit          xfer;
        tgt  = redir & 32'hFFFF_FFFC;
        xfer = model_req() && rdy;
        if (m_drain.size() != 0) begin
            if (xfer) begin
                m_pc = f ? tgt : m_drain[0];
                m_drain.delete();
            end else if (f) begin
                m_drain[0] = tgt;
            end
        end else if (m_held.size() != 0) begin
            if (f) begin
                m_held.delete();
                m_pc = tgt;
            end else if (!s) begin
                {m_instr, m_ifpc} = m_held.pop_front();
                m_valid = 1'b1;
            end
        end else begin
            if (f) begin
                if (xfer) m_pc = tgt;
                else      m_drain.push_back(tgt);
            end else if (xfer) begin
                if (s) m_held.push_back({mem_word(m_pc), m_pc});
                else begin
                    m_instr = mem_word(m_pc);
                    m_ifpc  = m_pc;
                    m_valid = 1'b1;
                end
                m_pc = m_pc + 32'd4;
            end else if (!s) begin
                m_instr = NOP;
                m_ifpc  = m_pc;
                m_valid = 1'b0;
            end
        end
        if (f) begin
            m_instr = NOP;
            m_valid = 1'b0;
        end
    endtask

    task automatic random_cycle(input int n);
        bit          s;
        bit          f;
        bit          rdy;
        logic [31:0] redir;
        s     = ($urandom_range(0, 3) == 0);
        f     = ($urandom_range(0, 9) == 0);
        rdy   = ($urandom_range(0, 9) < 7);
        redir = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'h0000_0FFF);
        stall       = s;
        flush       = f;
        imem_ready  = rdy;
        redirect_pc = redir;
        #1;
        check($sformatf("rnd%0d.req", n), 32'(imem_req), 32'(model_req()));
        if (model_req()) check($sformatf("rnd%0d.addr", n), imem_addr, m_pc);
        model_step(s, f, rdy, redir);
        @(posedge clk);
        #1;
        check($sformatf("rnd%0d.instr", n), IF_ID_instr, m_instr);
        check($sformatf("rnd%0d.pc", n),    IF_ID_pc,    m_ifpc);
        check($sformatf("rnd%0d.valid", n), 32'(IF_ID_valid), 32'(m_valid));
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        //            stall flush ready redir            req   addr           instr          pc             valid
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h0,          1'b1, 32'h0,         32'h0050_0093, 32'h0,         1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h0,          1'b1, 32'h4,         32'h00A0_0113, 32'h4,         1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h0,          1'b1, 32'h8,         32'h00A0_0113, 32'h4,         1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h0,          1'b0, 32'h0,         32'h00A0_0113, 32'h4,         1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h0,          1'b0, 32'h0,         32'h00B0_0193, 32'h8,         1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h0,          1'b1, 32'hC,         32'hC0DE_000C, 32'hC,         1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h100,        1'b1, 32'h10,        NOP,           32'hC,         1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h0,          1'b1, 32'h100,       32'hC0DE_0100, 32'h100,       1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h104,       NOP,           32'h104,       1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h104,       NOP,           32'h104,       1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0,          1'b1, 32'h104,       32'hC0DE_0104, 32'h104,       1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h200,        1'b1, 32'h108,       NOP,           32'h104,       1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h240,        1'b1, 32'h108,       NOP,           32'h104,       1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h108,       NOP,           32'h104,       1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h0,          1'b1, 32'h108,       NOP,           32'h104,       1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h0,          1'b1, 32'h240,       32'hC0DE_0240, 32'h240,       1'b1};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 32'h303,        1'b1, 32'h244,       NOP,           32'h240,       1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 32'h0,          1'b1, 32'h300,       32'hC0DE_0300, 32'h300,       1'b1};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE,  1'b1, 32'h304,       NOP,           32'h300,       1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 32'h0,          1'b1, 32'hFFFF_FFFC, 32'h3F21_FFFC, 32'hFFFF_FFFC, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 32'h0,          1'b1, 32'h0,         32'h0050_0093, 32'h0,         1'b1};
        vecs[21] = '{1'b1, 1'b0, 1'b1, 32'h0,          1'b1, 32'h4,         32'h0050_0093, 32'h0,         1'b1};
        vecs[22] = '{1'b1, 1'b1, 1'b0, 32'h80,         1'b0, 32'h0,         NOP,           32'h0,         1'b0};
        vecs[23] = '{1'b0, 1'b0, 1'b1, 32'h0,          1'b1, 32'h80,        32'hC0DE_0080, 32'h80,        1'b1};

        do_reset("init");
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset while draining an abandoned fetch.
        do_reset("pre_drain");
        run_vec('{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h0, 32'h0050_0093, 32'h0, 1'b1}, "drn0");
        run_vec('{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h4, 32'h00A0_0113, 32'h4, 1'b1}, "drn1");
        run_vec('{1'b0, 1'b1, 1'b0, 32'h40, 1'b1, 32'h8, NOP, 32'h4, 1'b0}, "drn2");
        async_reset_check("rst_drain");

        // Reset while a stalled word sits in the buffer.
        run_vec('{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h4, 32'h00A0_0113, 32'h4, 1'b1}, "buf0");
        run_vec('{1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 32'h8, 32'h00A0_0113, 32'h4, 1'b1}, "buf1");
        run_vec('{1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h00A0_0113, 32'h4, 1'b1}, "buf2");
        async_reset_check("rst_buf");

        // Randomized traffic against the model.
        do_reset("pre_rnd");
        model_reset();
        for (int n = 0; n < 3000; n++) random_cycle(n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
